// File: rtl/pwm_duty_decoder.sv
// PWM receive path: synchronises pwm_in, measures period and high time between rising edges,
// and converts them to an 8-bit duty code with an 8-cycle restoring divider.
module pwm_duty_decoder #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             pwm_in,
    output logic [7:0]       duty_out,
    output logic             duty_valid,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic             busy,
    output logic             overrun,
    output logic             stuck
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        DIVIDE  = 2'd2
    } state_t;

    // Timeout fires on the cycle the period count would step onto all-ones.
    localparam logic [CNT_W-1:0] TO_CNT = {{(CNT_W-1){1'b1}}, 1'b0};

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level;
    logic                   level_d;
    logic                   rise;
    logic                   counting;
    logic                   timeout;
    logic                   to_level;
    logic                   pend_to;
    logic                   pend_lvl;
    logic [CNT_W-1:0]       per_cnt;
    logic [CNT_W-1:0]       hi_cnt;
    logic [CNT_W-1:0]       div_p;
    logic [CNT_W-1:0]       div_h;
    logic [CNT_W+7:0]       num;
    logic [CNT_W-1:0]       rem;
    logic [CNT_W:0]         trial;
    logic [CNT_W-1:0]       rem_next;
    logic                   take;
    logic [7:0]             num_lo;
    logic [7:0]             quo;
    logic [7:0]             quo_next;
    logic [2:0]             step;

    assign level    = sync_q[SYNC_STAGES-1];
    assign rise     = level & ~level_d;
    assign counting = (state != IDLE);
    assign timeout  = counting && !rise && (per_cnt == TO_CNT);
    assign to_level = pend_to ? pend_lvl : level;
    assign overrun  = ena && rise && (state == DIVIDE);

    // H*255 never exceeds 256*P, so the top CNT_W bits seed the remainder below P.
    assign num = ({8'd0, hi_cnt} << 8) - {8'd0, hi_cnt};

    always_comb begin
        trial    = {rem, num_lo[7]};
        take     = (trial >= {1'b0, div_p}) && (div_p != '0);
        rem_next = take ? CNT_W'(trial - {1'b0, div_p}) : trial[CNT_W-1:0];
        quo_next = {quo[6:0], take};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q     <= '0;
            level_d    <= 1'b0;
            state      <= IDLE;
            per_cnt    <= '0;
            hi_cnt     <= '0;
            div_p      <= '0;
            div_h      <= '0;
            rem        <= '0;
            num_lo     <= '0;
            quo        <= '0;
            step       <= '0;
            pend_to    <= 1'b0;
            pend_lvl   <= 1'b0;
            duty_out   <= '0;
            duty_valid <= 1'b0;
            period_out <= '0;
            high_out   <= '0;
            busy       <= 1'b0;
            stuck      <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], pwm_in};
            level_d    <= level;
            duty_valid <= 1'b0;
            if (!ena) begin
                state   <= IDLE;
                per_cnt <= '0;
                hi_cnt  <= '0;
                busy    <= 1'b0;
                pend_to <= 1'b0;
            end else begin
                if (rise) begin
                    per_cnt <= CNT_W'(1);
                    hi_cnt  <= CNT_W'(1);
                end else if (timeout) begin
                    per_cnt <= '0;
                    hi_cnt  <= '0;
                end else if (counting) begin
                    per_cnt <= per_cnt + CNT_W'(1);
                    hi_cnt  <= hi_cnt + CNT_W'(level);
                end

                case (state)
                    IDLE: begin
                        if (rise) state <= MEASURE;
                    end
                    MEASURE: begin
                        if (timeout || pend_to) begin
                            duty_out   <= {8{to_level}};
                            period_out <= '0;
                            high_out   <= '0;
                            duty_valid <= 1'b1;
                            stuck      <= 1'b1;
                        end
                        pend_to <= 1'b0;
                        if (rise) begin
                            div_p  <= per_cnt;
                            div_h  <= hi_cnt;
                            rem    <= num[CNT_W+7:8];
                            num_lo <= num[7:0];
                            quo    <= '0;
                            step   <= '0;
                            busy   <= 1'b1;
                            state  <= DIVIDE;
                        end
                    end
                    DIVIDE: begin
                        rem    <= rem_next;
                        num_lo <= {num_lo[6:0], 1'b0};
                        quo    <= quo_next;
                        step   <= step + 3'd1;
                        // A timeout during a divide is reported once the result is out.
                        if (timeout) begin
                            pend_to  <= 1'b1;
                            pend_lvl <= level;
                        end
                        if (step == 3'd7) begin
                            duty_out   <= quo_next;
                            period_out <= div_p;
                            high_out   <= div_h;
                            duty_valid <= 1'b1;
                            busy       <= 1'b0;
                            state      <= MEASURE;
                        end
                    end
                    default: state <= IDLE;
                endcase

                if (rise) stuck <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Randomised bench for pwm_duty_decoder: predicts each cycle's outputs from edge times,
// counted high cycles and plain integer division.
module tb_pwm_duty_decoder;

    localparam int CNT_W = 8;
    localparam int TMO   = (1 << CNT_W) - 1;
    localparam int MAXC  = 40000;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             ena = 1'b0;
    logic             pwm_in = 1'b0;
    logic [7:0]       duty_out;
    logic             duty_valid;
    logic [CNT_W-1:0] period_out;
    logic [CNT_W-1:0] high_out;
    logic             busy;
    logic             overrun;
    logic             stuck;

    always #5 clk = ~clk;

    pwm_duty_decoder #(.CNT_W(CNT_W), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .pwm_in     (pwm_in),
        .duty_out   (duty_out),
        .duty_valid (duty_valid),
        .period_out (period_out),
        .high_out   (high_out),
        .busy       (busy),
        .overrun    (overrun),
        .stuck      (stuck)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit d_hist [MAXC];
    bit r_hist [MAXC];

    // reference model state: counting origin, pending divide, expected outputs
    bit active = 0, div_on = 0, pend = 0, pend_lvl = 0;
    int base = 0, e_t = 0, e_duty = 0, e_p = 0, e_h = 0;
    bit have_x = 0, x_valid = 0, x_busy = 0, x_stuck = 0;
    int x_duty = 0, x_per = 0, x_high = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    // synchronised level seen by the design in cycle c (two-flop delay, cleared by reset)
    function automatic bit lvl_at(input int c);
        if (c < 2) return 1'b0;
        if (r_hist[c-1] || r_hist[c-2]) return 1'b0;
        return d_hist[c-2];
    endfunction

    task automatic tick(input bit p, input bit r, input bit e);
        bit rs, ind, tmo, fin, ov;
        int c;
        @(negedge clk);
        c = cyc;
        if (c >= MAXC - 1) begin
            $display("FAIL history_overflow cycle %0d", c);
            $fatal(1);
        end
        if (have_x) begin
            check_val("duty_valid", duty_valid, x_valid);
            check_val("busy", busy, x_busy);
            check_val("stuck", stuck, x_stuck);
            check_val("duty_out", duty_out, x_duty);
            check_val("period_out", period_out, x_per);
            check_val("high_out", high_out, x_high);
        end
        pwm_in = p;
        rst = r;
        ena = e;
        d_hist[c] = p;
        r_hist[c] = r;

        rs  = lvl_at(c) && !lvl_at(c - 1);
        ind = div_on && (c >= e_t + 1) && (c <= e_t + 8);
        ov  = e && rs && ind;
        x_valid = 0;
        if (r) begin
            active = 0; div_on = 0; pend = 0;
            x_duty = 0; x_per = 0; x_high = 0; x_busy = 0; x_stuck = 0;
        end else if (!e) begin
            active = 0; div_on = 0; pend = 0; x_busy = 0;
        end else begin
            tmo = active && !rs && (c + 1 - base == TMO);
            fin = ind && (c == e_t + 8);
            if (fin) begin
                x_duty = e_duty; x_per = e_p; x_high = e_h; x_valid = 1; div_on = 0;
            end
            if (active && !ind && (tmo || pend)) begin
                x_duty = (pend ? pend_lvl : lvl_at(c)) ? 255 : 0;
                x_per = 0; x_high = 0; x_valid = 1; x_stuck = 1; pend = 0;
            end
            if (ind && tmo) begin
                pend = 1; pend_lvl = lvl_at(c);
            end
            if (tmo) base = c + 1;
            if (rs) begin
                x_stuck = 0;
                if (active && !ind) begin
                    e_t = c;
                    e_p = c - base;
                    e_h = 0;
                    for (int k = base; k < c; k++) e_h += int'(lvl_at(k));
                    e_duty = (e_p == 0) ? 0 : (e_h * 255) / e_p;
                    div_on = 1;
                end
                active = 1;
                base = c;
            end
            x_busy = div_on && (c + 1 <= e_t + 8);
        end
        have_x = 1;
        #1;
        check_val("overrun", overrun, ov);
        cyc++;
    endtask

    task automatic run_period(input int p, input int h, input bit e);
        for (int i = 0; i < p; i++) tick(i < h, 1'b0, e);
    endtask

    task automatic hold(input bit v, input int n);
        for (int i = 0; i < n; i++) tick(v, 1'b0, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) tick(i[0], 1'b1, 1'b1);
        hold(1'b0, 3);
        repeat (4) run_period(100, 25, 1'b1);
        repeat (3) run_period(20, 19, 1'b1);
        repeat (3) run_period(20, 1, 1'b1);
        hold(1'b1, 600);
        repeat (2) run_period(30, 10, 1'b1);
        hold(1'b0, 600);
        repeat (2) run_period(30, 10, 1'b1);
        repeat (10) run_period(6, 3, 1'b1);

        repeat (2) run_period(40, 10, 1'b1);
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 1'b1);
        repeat (3) run_period(40, 10, 1'b1);
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        repeat (3) run_period(40, 10, 1'b1);

        repeat (150) begin
            int sel, p, h, n;
            sel = int'($urandom_range(0, 19));
            if (sel == 0) begin
                n = int'($urandom_range(260, 400));
                hold(1'($urandom_range(0, 1)), n);
            end else if (sel == 1) begin
                n = int'($urandom_range(1, 5));
                for (int i = 0; i < n; i++) tick(pwm_in, 1'b0, 1'b0);
            end else begin
                p = int'($urandom_range(2, 70));
                h = int'($urandom_range(1, p - 1));
                run_period(p, h, 1'b1);
            end
        end
        hold(1'b0, 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
